// File: rtl/sbox_share_sched_pkg.sv
// Shared definitions for the S-box bank scheduler: block geometry, FSM
// states and the GF(2^8) arithmetic behind a single AES S-box lane.
package sbox_share_sched_pkg;

    localparam int AES_WORD      = 32;
    localparam int AES_BLK       = 128;
    localparam int WORDS_PER_BLK = 4;
    localparam int SBOX_LANES    = AES_WORD / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SUB_KS = 3'd1,
        S_SUB_ST = 3'd2,
        S_RSP_KS = 3'd3,
        S_RSP_ST = 3'd4
    } state_e;

    // Block viewed as words; index 3 is the most significant word (byte 0 first).
    typedef logic [WORDS_PER_BLK-1:0][AES_WORD-1:0] blk_t;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // Forward S-box = affine(inverse); inverse S-box = inverse(inverse affine).
    function automatic logic [7:0] sbox_byte(input logic [7:0] x, input logic dec);
        logic [7:0] t;
        if (dec) begin
            t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
            return gf_inv(t);
        end
        t = gf_inv(x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_share_sched_if.sv
// Request/response bundle between the two requesters and the scheduler.
interface sbox_share_sched_if;
    import sbox_share_sched_pkg::*;

    logic                ks_req_valid;
    logic                ks_req_ready;
    logic [AES_WORD-1:0] ks_req_word;
    logic                ks_rsp_valid;
    logic                ks_rsp_ready;
    logic [AES_WORD-1:0] ks_rsp_word;
    logic                st_req_valid;
    logic                st_req_ready;
    logic [AES_BLK-1:0]  st_req_data;
    logic                st_req_dec;
    logic                st_rsp_valid;
    logic                st_rsp_ready;
    logic [AES_BLK-1:0]  st_rsp_data;
    logic                busy;

    modport master (
        output ks_req_valid, ks_req_word, ks_rsp_ready,
        output st_req_valid, st_req_data, st_req_dec, st_rsp_ready,
        input  ks_req_ready, ks_rsp_valid, ks_rsp_word,
        input  st_req_ready, st_rsp_valid, st_rsp_data, busy
    );

    modport slave (
        input  ks_req_valid, ks_req_word, ks_rsp_ready,
        input  st_req_valid, st_req_data, st_req_dec, st_rsp_ready,
        output ks_req_ready, ks_rsp_valid, ks_rsp_word,
        output st_req_ready, st_rsp_valid, st_rsp_data, busy
    );

endinterface

// File: rtl/sbox_share_sched_subbyte.sv
// SubByte_32: four S-box lanes on one 32-bit word, direction shared.
module sbox_share_sched_subbyte
    import sbox_share_sched_pkg::*;
(
    input  logic [AES_WORD-1:0] din,
    input  logic                dec,
    output logic [AES_WORD-1:0] dout
);

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        assign dout[8*g +: 8] = sbox_byte(din[8*g +: 8], dec);
    end

endmodule

// File: rtl/sbox_share_sched.sv
// Time-multiplexes one 32-bit S-box bank between the key schedule (one
// forward SubWord) and the round datapath (128-bit block over four cycles).
module sbox_share_sched
    import sbox_share_sched_pkg::*;
#(
    parameter bit ARB_RR = 1'b1,
    parameter bit KS_PRI = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sbox_share_sched_if.slave  bus
);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                rr_ks_q, rr_ks_d;   // 1: key schedule won last
    blk_t                buf_q, buf_d;
    logic                dec_q, dec_d;
    logic [AES_WORD-1:0] ks_res_q, ks_res_d;
    blk_t                st_res_q, st_res_d;

    logic                gnt_ks, gnt_st;
    logic [1:0]          widx;
    logic [AES_WORD-1:0] sbox_in, sbox_out;
    logic                sbox_dec;

    sbox_share_sched_subbyte u_subbyte (
        .din  (sbox_in),
        .dec  (sbox_dec),
        .dout (sbox_out)
    );

    // Arbiter: lone requester wins; a tie goes round-robin or to the fixed favourite.
    always_comb begin
        gnt_ks = bus.ks_req_valid;
        gnt_st = bus.st_req_valid;
        if (bus.ks_req_valid && bus.st_req_valid) begin
            gnt_ks = ARB_RR ? !rr_ks_q : KS_PRI;
            gnt_st = !gnt_ks;
        end
    end

    // Word cnt 0 is the most significant word of the block.
    assign widx = ~cnt_q;

    // FSM next state, S-box steering and result capture.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rr_ks_d          = rr_ks_q;
        buf_d            = buf_q;
        dec_d            = dec_q;
        ks_res_d         = ks_res_q;
        st_res_d         = st_res_q;
        sbox_in          = '0;
        sbox_dec         = 1'b0;
        bus.ks_req_ready = 1'b0;
        bus.st_req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.ks_req_ready = gnt_ks;
                bus.st_req_ready = gnt_st;
                if (gnt_ks) begin
                    buf_d    = '0;
                    buf_d[0] = bus.ks_req_word;
                    dec_d    = 1'b0;
                    rr_ks_d  = 1'b1;
                    state_d  = S_SUB_KS;
                end else if (gnt_st) begin
                    buf_d   = bus.st_req_data;
                    dec_d   = bus.st_req_dec;
                    rr_ks_d = 1'b0;
                    state_d = S_SUB_ST;
                end
            end
            S_SUB_KS: begin
                sbox_in  = buf_q[0];
                ks_res_d = sbox_out;
                state_d  = S_RSP_KS;
            end
            S_SUB_ST: begin
                sbox_in        = buf_q[widx];
                sbox_dec       = dec_q;
                st_res_d[widx] = sbox_out;
                cnt_d          = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_RSP_ST;
            end
            S_RSP_KS: if (bus.ks_rsp_ready) state_d = S_IDLE;
            S_RSP_ST: if (bus.st_rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            rr_ks_q  <= 1'b0;
            buf_q    <= '0;
            dec_q    <= 1'b0;
            ks_res_q <= '0;
            st_res_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ks_q  <= rr_ks_d;
            buf_q    <= buf_d;
            dec_q    <= dec_d;
            ks_res_q <= ks_res_d;
            st_res_q <= st_res_d;
        end
    end

    assign bus.ks_rsp_valid = (state_q == S_RSP_KS);
    assign bus.st_rsp_valid = (state_q == S_RSP_ST);
    assign bus.ks_rsp_word  = ks_res_q;
    assign bus.st_rsp_data  = st_res_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed + randomized bench for sbox_share_sched; S-box reference tables
// are generated from the field's generator walk, independent of the RTL.
module tb_sbox_share_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sbox_share_sched_if ifa ();
    sbox_share_sched_if ifb ();

    sbox_share_sched #(.ARB_RR(1'b1), .KS_PRI(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ifa));
    sbox_share_sched #(.ARB_RR(1'b0), .KS_PRI(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ifb));

    int checks = 0;
    int errors = 0;
    logic [7:0] sb  [0:255];
    logic [7:0] isb [0:255];

    function automatic logic [7:0] rol8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // Walk p over powers of 3 and q over powers of 3^-1 to fill the tables.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] w, input bit dec);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = dec ? isb[w[8*i +: 8]] : sb[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref_blk(input logic [127:0] b, input bit dec);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_word(b[32*i +: 32], dec);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended transaction on the round-robin instance, with hold cycles of backpressure.
    task automatic txn(input bit is_ks, input logic [127:0] d, input bit dec, input int hold,
                       output logic [127:0] got);
        logic [127:0] exp;
        int n;
        exp = is_ks ? {96'b0, ref_word(d[31:0], 1'b0)} : ref_blk(d, dec);
        if (is_ks) begin
            ifa.ks_req_valid = 1'b1; ifa.ks_req_word = d[31:0];
        end else begin
            ifa.st_req_valid = 1'b1; ifa.st_req_data = d; ifa.st_req_dec = dec;
        end
        #1;
        n = 0;
        while (!(is_ks ? ifa.ks_req_ready : ifa.st_req_ready) && n < 16) begin tick(); #1; n++; end
        chk("txn_grant", is_ks ? ifa.ks_req_ready : ifa.st_req_ready, 1);
        tick();
        ifa.ks_req_valid = 1'b0;
        ifa.st_req_valid = 1'b0;
        ifa.ks_req_word  = $urandom;
        ifa.st_req_data  = {$urandom, $urandom, $urandom, $urandom};
        ifa.st_req_dec   = ~dec;
        #1;
        for (int c = 1; c < (is_ks ? 2 : 5); c++) begin
            chk("txn_early_rsp", {ifa.ks_rsp_valid, ifa.st_rsp_valid}, 0);
            chk("txn_busy", ifa.busy, 1);
            tick(); #1;
        end
        chk("txn_rsp_valid", is_ks ? ifa.ks_rsp_valid : ifa.st_rsp_valid, 1);
        got = is_ks ? {96'b0, ifa.ks_rsp_word} : ifa.st_rsp_data;
        chk("txn_data", got, exp);
        for (int h = 0; h < hold; h++) begin
            tick(); #1;
            chk("txn_hold_valid", is_ks ? ifa.ks_rsp_valid : ifa.st_rsp_valid, 1);
            chk("txn_hold_data", is_ks ? {96'b0, ifa.ks_rsp_word} : ifa.st_rsp_data, exp);
        end
        if (is_ks) ifa.ks_rsp_ready = 1'b1; else ifa.st_rsp_ready = 1'b1;
        tick();
        ifa.ks_rsp_ready = 1'b0;
        ifa.st_rsp_ready = 1'b0;
        #1;
        chk("txn_done", {ifa.busy, ifa.ks_rsp_valid, ifa.st_rsp_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] got, exp, sd;
        logic [31:0]  kw;
        bit           sdec, won;
        int           n;

        build_tables();
        ifa.ks_req_valid = 0; ifa.ks_req_word = 0; ifa.ks_rsp_ready = 0;
        ifa.st_req_valid = 0; ifa.st_req_data = 0; ifa.st_req_dec = 0; ifa.st_rsp_ready = 0;
        ifb.ks_req_valid = 0; ifb.ks_req_word = 0; ifb.ks_rsp_ready = 0;
        ifb.st_req_valid = 0; ifb.st_req_data = 0; ifb.st_req_dec = 0; ifb.st_rsp_ready = 0;
        rst = 1'b1;
        repeat (3) tick();
        #1;
        chk("reset_ctrl", {ifa.busy, ifa.ks_req_ready, ifa.st_req_ready, ifa.ks_rsp_valid, ifa.st_rsp_valid}, 0);
        chk("reset_res", {ifa.ks_rsp_word, ifa.st_rsp_data}, 0);
        chk("reset_fp_ctrl", {ifb.busy, ifb.ks_rsp_valid, ifb.st_rsp_valid}, 0);
        rst = 1'b0;
        tick();

        // Known-answer vectors.
        txn(1'b1, 128'hcf4f3c09, 1'b0, 2, got);
        chk("t1_ks_vec", got, 128'h8a84eb01);
        txn(1'b0, 128'h00102030405060708090a0b0c0d0e0f0, 1'b0, 1, got);
        chk("t2_st_fwd", got, 128'h63cab7040953d051cd60e0e7ba70e18c);
        txn(1'b0, 128'h63cab7040953d051cd60e0e7ba70e18c, 1'b1, 0, got);
        chk("t3_st_inv", got, 128'h00102030405060708090a0b0c0d0e0f0);
        txn(1'b0, 128'h0, 1'b1, 0, got);
        chk("t3_inv_zero", got, {16{8'h52}});

        // Round-robin contention from reset: KS, ST, KS, ST.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kw = $urandom; sd = {$urandom, $urandom, $urandom, $urandom}; sdec = 1'($urandom);
        ifa.ks_req_valid = 1; ifa.ks_req_word = kw;
        ifa.st_req_valid = 1; ifa.st_req_data = sd; ifa.st_req_dec = sdec;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_grant_now", ifa.ks_req_ready | ifa.st_req_ready, 1);
            chk("t4_order", ifa.ks_req_ready, (k % 2 == 0));
            chk("t4_one_grant", ifa.ks_req_ready & ifa.st_req_ready, 0);
            won = ifa.ks_req_ready;
            exp = won ? {96'b0, ref_word(kw, 1'b0)} : ref_blk(sd, sdec);
            tick();
            if (won) begin kw = $urandom; ifa.ks_req_word = kw; ifa.st_rsp_ready = 1; end
            else begin
                sd = {$urandom, $urandom, $urandom, $urandom}; sdec = 1'($urandom);
                ifa.st_req_data = sd; ifa.st_req_dec = sdec; ifa.ks_rsp_ready = 1;
            end
            #1;
            n = 0;
            while (!(won ? ifa.ks_rsp_valid : ifa.st_rsp_valid) && n < 10) begin tick(); #1; n++; end
            chk("t4_latency", n, won ? 1 : 4);
            chk("t4_data", won ? {96'b0, ifa.ks_rsp_word} : ifa.st_rsp_data, exp);
            ifa.ks_rsp_ready = 1; ifa.st_rsp_ready = 1;
            tick();
            ifa.ks_rsp_ready = 0; ifa.st_rsp_ready = 0;
            #1;
        end
        ifa.ks_req_valid = 0; ifa.st_req_valid = 0;

        // Fixed priority favouring the datapath: ST wins every tie.
        kw = $urandom;
        ifb.ks_req_valid = 1; ifb.ks_req_word = kw;
        ifb.st_req_valid = 1;
        for (int k = 0; k < 3; k++) begin
            sd = {$urandom, $urandom, $urandom, $urandom}; sdec = 1'($urandom);
            ifb.st_req_data = sd; ifb.st_req_dec = sdec;
            #1;
            n = 0;
            while (!(ifb.st_req_ready || ifb.ks_req_ready) && n < 16) begin tick(); #1; n++; end
            chk("t4b_st_wins", {ifb.st_req_ready, ifb.ks_req_ready}, 2'b10);
            tick(); #1;
            n = 0;
            while (!ifb.st_rsp_valid && n < 10) begin tick(); #1; n++; end
            chk("t4b_data", ifb.st_rsp_data, ref_blk(sd, sdec));
            ifb.st_rsp_ready = 1;
            tick();
            ifb.st_rsp_ready = 0;
        end
        ifb.st_req_valid = 0;
        #1;
        chk("t4b_ks_after", ifb.ks_req_ready, 1);
        tick();
        ifb.ks_req_valid = 0;
        #1;
        n = 0;
        while (!ifb.ks_rsp_valid && n < 10) begin tick(); #1; n++; end
        chk("t4b_ks_data", ifb.ks_rsp_word, ref_word(kw, 1'b0));
        ifb.ks_rsp_ready = 1;
        tick();
        ifb.ks_rsp_ready = 0;

        // Backpressure on the datapath response with a key-schedule request waiting.
        sd = {$urandom, $urandom, $urandom, $urandom}; sdec = 1'($urandom);
        ifa.st_req_valid = 1; ifa.st_req_data = sd; ifa.st_req_dec = sdec;
        #1;
        chk("t5_st_grant", ifa.st_req_ready, 1);
        tick();
        kw = $urandom;
        ifa.st_req_valid = 0; ifa.ks_req_valid = 1; ifa.ks_req_word = kw;
        #1;
        chk("t5_ks_blocked", ifa.ks_req_ready, 0);
        n = 0;
        while (!ifa.st_rsp_valid && n < 10) begin tick(); #1; n++; end
        for (int h = 0; h < 10; h++) begin
            chk("t5_hold_data", ifa.st_rsp_data, ref_blk(sd, sdec));
            chk("t5_hold_ctrl", {ifa.st_rsp_valid, ifa.busy, ifa.ks_req_ready}, 3'b110);
            tick(); #1;
        end
        ifa.st_rsp_ready = 1;
        tick();
        ifa.st_rsp_ready = 0;
        #1;
        chk("t5_ks_grant_next", {ifa.ks_req_ready, ifa.busy}, 2'b10);
        tick();
        ifa.ks_req_valid = 0;
        #1;
        n = 0;
        while (!ifa.ks_rsp_valid && n < 10) begin tick(); #1; n++; end
        chk("t5_ks_latency", n, 1);
        chk("t5_ks_data", ifa.ks_rsp_word, ref_word(kw, 1'b0));
        ifa.ks_rsp_ready = 1;
        tick();
        ifa.ks_rsp_ready = 0;

        // Reset mid-substitution (cnt=2) discards the block.
        ifa.st_req_valid = 1; ifa.st_req_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("t6_grant", ifa.st_req_ready, 1);
        tick();
        ifa.st_req_valid = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ctrl", {ifa.busy, ifa.ks_req_ready, ifa.st_req_ready, ifa.ks_rsp_valid, ifa.st_rsp_valid}, 0);
        chk("t6_res", {ifa.ks_rsp_word, ifa.st_rsp_data}, 0);
        for (int c = 0; c < 6; c++) begin
            tick(); #1;
            chk("t6_no_rsp", {ifa.st_rsp_valid, ifa.busy}, 0);
        end
        ifa.ks_req_valid = 1; ifa.st_req_valid = 1;
        #1;
        chk("t6_rr_reset", {ifa.ks_req_ready, ifa.st_req_ready}, 2'b10);
        ifa.ks_req_valid = 0; ifa.st_req_valid = 0;
        sd = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b0, sd, 1'b0, 1, got);

        // Randomized single transactions with random backpressure.
        for (int r = 0; r < 24; r++) begin
            txn(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                int'($urandom_range(0, 3)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
